// File: rtl/riscv_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam int PC_INC = 4;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head word is readable without a pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; stale words are never visible because the
  // consumer masks the head with its valid flag.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end with prefetch queue and redirect/miss handling.
// Optional same-cycle bypass of an empty queue: define FETCHQ_BYPASS_EN.
module riscv_fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        ICACHE_ren,
  output logic [29:0]                 ICACHE_addr,
  input  logic                        ICACHE_stall,
  input  logic [XLEN-1:0]             ICACHE_rdata,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  input  logic                        dec_ready,
  output logic                        dec_valid,
  output logic [XLEN-1:0]             dec_instr,
  output logic [XLEN-1:0]             dec_pc,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int CW = cnt_width(DEPTH);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] pending_pc_reg, pending_pc_next;
  logic [XLEN-1:0] redirect_aligned;
  logic            full, empty, resp, push, pop, bypass;
  fetch_entry_t    wr_entry, head_entry, out_entry;

  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  // DROP keeps the orphaned request alive so the cache sees a stable handshake.
  assign ICACHE_ren  = ((state_reg == FETCH) & ~full) | (state_reg == DROP);
  assign ICACHE_addr = fetch_pc_reg[31:2];
  assign resp        = ICACHE_ren & ~ICACHE_stall;
  assign wr_entry    = '{pc: fetch_pc_reg, instr: ICACHE_rdata};

`ifdef FETCHQ_BYPASS_EN
  assign bypass = empty & resp & (state_reg == FETCH) & ~redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  assign dec_valid = (~empty | bypass) & (state_reg != DROP);
  assign out_entry = bypass ? wr_entry : head_entry;
  assign dec_instr = dec_valid ? out_entry.instr : '0;
  assign dec_pc    = dec_valid ? out_entry.pc : '0;

  // A bypassed response that decode takes right away never enters the queue.
  assign push = resp & (state_reg == FETCH) & ~redirect_valid & ~(bypass & dec_ready);
  assign pop  = ~empty & dec_valid & dec_ready & ~redirect_valid;

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    pending_pc_next = pending_pc_reg;
    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (redirect_valid) begin
          if (ICACHE_ren & ICACHE_stall) begin
            state_next      = DROP;
            pending_pc_next = redirect_aligned;
          end else begin
            fetch_pc_next = redirect_aligned;
          end
        end else if (resp) begin
          fetch_pc_next = fetch_pc_reg + XLEN'(PC_INC);
        end
      end
      DROP: begin
        if (redirect_valid) pending_pc_next = redirect_aligned;
        if (~ICACHE_stall) begin
          fetch_pc_next = redirect_valid ? redirect_aligned : pending_pc_reg;
          state_next    = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= RESET_PC;
      pending_pc_reg <= RESET_PC;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      pending_pc_reg <= pending_pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(2 * XLEN),
    .CW   (CW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .wdata(wr_entry),
    .rdata(head_entry),
    .full (full),
    .empty(empty),
    .count(count)
  );

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed self-checking bench for riscv_fetch_queue (default build, DEPTH=4).
module tb_riscv_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_ren;
  logic [29:0] icache_addr;
  logic        icache_stall;
  logic [31:0] icache_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Cache model: instruction word is a tag plus the word address.
  assign icache_rdata = 32'hC000_0000 | {2'b00, icache_addr};

  riscv_fetch_queue #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .ICACHE_ren    (icache_ren),
    .ICACHE_addr   (icache_addr),
    .ICACHE_stall  (icache_stall),
    .ICACHE_rdata  (icache_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_ready     (dec_ready),
    .dec_valid     (dec_valid),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .count         (count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".ren"},   32'(icache_ren), 32'd0);
    check_val({tag, ".valid"}, 32'(dec_valid),  32'd0);
    check_val({tag, ".count"}, 32'(count),      32'd0);
    check_val({tag, ".pc"},    dec_pc,          32'd0);
    check_val({tag, ".instr"}, dec_instr,       32'd0);
  endtask

  initial begin
    rst = 1'b1; icache_stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; dec_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check_reset_outputs("reset");

    rst = 1'b0;
    #1 check_val("idle.ren", 32'(icache_ren), 32'd0);
    step();
    check_val("first.ren",   32'(icache_ren),  32'd1);
    check_val("first.addr",  32'(icache_addr), 32'd0);
    check_val("first.valid", 32'(dec_valid),   32'd0);
    step();

    // Zero-wait streaming: one entry in flight, PCs 0,4,8,...
    for (int k = 1; k <= 5; k++) begin
      check_val($sformatf("stream%0d.addr", k),  32'(icache_addr), 32'(k));
      check_val($sformatf("stream%0d.pc", k),    dec_pc,           32'((k - 1) * 4));
      check_val($sformatf("stream%0d.instr", k), dec_instr,        32'hC000_0000 | 32'(k - 1));
      check_val($sformatf("stream%0d.count", k), 32'(count),       32'd1);
      step();
    end

    // Stall decode: fill to DEPTH.
    dec_ready = 1'b0;
    check_val("fill0.addr", 32'(icache_addr), 32'd6);
    check_val("fill0.pc",   dec_pc,           32'd20);
    step(); check_val("fill1.count", 32'(count), 32'd2);
    step(); check_val("fill2.count", 32'(count), 32'd3);
    step();
    check_val("full.count", 32'(count),      32'd4);
    check_val("full.ren",   32'(icache_ren), 32'd0);
    check_val("full.addr",  32'(icache_addr), 32'd9);
    step();
    check_val("full_hold.count", 32'(count), 32'd4);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check_val("pop1.count", 32'(count),      32'd3);
    check_val("pop1.ren",   32'(icache_ren), 32'd1);
    check_val("pop1.pc",    dec_pc,          32'd24);
    step();
    check_val("refill.count", 32'(count),       32'd4);
    check_val("refill.ren",   32'(icache_ren),  32'd0);
    check_val("refill.addr",  32'(icache_addr), 32'd10);

    // Redirect with no request outstanding, then a 5-cycle miss at 0x40.
    redirect_valid = 1'b1; redirect_pc = 32'h40; icache_stall = 1'b1; dec_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check_val("redir40.count", 32'(count),     32'd0);
    check_val("redir40.valid", 32'(dec_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("miss%0d.ren", i),  32'(icache_ren),  32'd1);
      check_val($sformatf("miss%0d.addr", i), 32'(icache_addr), 32'h10);
      check_val($sformatf("miss%0d.count", i), 32'(count),      32'd0);
      step();
    end
    icache_stall = 1'b0;
    check_val("missdone.addr", 32'(icache_addr), 32'h10);
    step();
    dec_ready = 1'b0;
    check_val("missresp.valid", 32'(dec_valid),   32'd1);
    check_val("missresp.pc",    dec_pc,           32'h40);
    check_val("missresp.instr", dec_instr,        32'hC000_0010);
    check_val("missresp.count", 32'(count),       32'd1);
    check_val("missresp.addr",  32'(icache_addr), 32'h11);
    step();
    check_val("two.count", 32'(count),       32'd2);
    check_val("two.addr",  32'(icache_addr), 32'h12);

    // Redirect coincident with a response and a pop request.
    redirect_valid = 1'b1; redirect_pc = 32'h100; dec_ready = 1'b1;
    step();
    redirect_valid = 1'b0; dec_ready = 1'b0; icache_stall = 1'b1;
    check_val("redir100.count", 32'(count),       32'd0);
    check_val("redir100.valid", 32'(dec_valid),   32'd0);
    check_val("redir100.addr",  32'(icache_addr), 32'h40);
    step();

    // Redirect during a miss: the old response must be dropped.
    check_val("drop_pre.addr", 32'(icache_addr), 32'h40);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    check_val("drop.ren",   32'(icache_ren),  32'd1);
    check_val("drop.addr",  32'(icache_addr), 32'h40);
    check_val("drop.valid", 32'(dec_valid),   32'd0);
    step();
    icache_stall = 1'b0;
    check_val("drop_end.addr",  32'(icache_addr), 32'h40);
    check_val("drop_end.valid", 32'(dec_valid),   32'd0);
    step();
    check_val("post_drop.addr",  32'(icache_addr), 32'h80);
    check_val("post_drop.count", 32'(count),       32'd0);
    check_val("post_drop.valid", 32'(dec_valid),   32'd0);
    step();
    check_val("t200.valid", 32'(dec_valid), 32'd1);
    check_val("t200.pc",    dec_pc,         32'h200);
    check_val("t200.instr", dec_instr,      32'hC000_0080);
    check_val("t200.count", 32'(count),     32'd1);
    step(); step();
    check_val("three.count", 32'(count),       32'd3);
    check_val("three.addr",  32'(icache_addr), 32'h83);
    icache_stall = 1'b1;
    step();
    check_val("miss3.ren", 32'(icache_ren), 32'd1);

    // Asynchronous reset mid-miss.
    rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0; icache_stall = 1'b0;
    #1 check_val("rel_idle.ren", 32'(icache_ren), 32'd0);
    step();
    check_val("rel_fetch.ren",  32'(icache_ren),  32'd1);
    check_val("rel_fetch.addr", 32'(icache_addr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
